lmdpl_phase_ctrl: RTL



---
 rtl/lmdpl_phase_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/lmdpl_phase_ctrl.sv
// lmdpl_phase_ctrl: sequences mask refresh, precharge and one-at-a-time stage release for a pipeline of LMDPL gadget layers.
module lmdpl_phase_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int PRE_CYCLES = 1,
    parameter bit REFRESH_EN = 1'b1
) (
    input  logic                  C,
    input  logic                  RN,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  RND_VALID,
    output logic                  RND_REQ,
    output logic                  MASK_EN,
    output logic [NUM_STAGES-1:0] PRE,
    output logic [NUM_STAGES-1:0] EN,
    output logic [3:0]            STAGE,
    output logic                  BUSY,
    output logic                  DONE
);
    typedef enum logic [2:0] {S_IDLE, S_REFRESH, S_PRE, S_EVAL, S_DONE} state_t;
    localparam logic [NUM_STAGES-1:0] ONES     = '1;
    localparam logic [3:0]            LAST     = 4'(NUM_STAGES - 1);
    localparam logic [3:0]            PRE_LAST = 4'(PRE_CYCLES - 1);
    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [3:0]              stage_q;
    logic [NUM_STAGES-1:0]   pre_q;
    logic [NUM_STAGES-1:0]   en_q;
    logic                    req_q;
    logic                    mask_q;
    logic                    busy_q;
    logic                    done_q;
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            stage_q <= 4'd0;
            pre_q   <= ONES;
            en_q    <= '0;
            req_q   <= 1'b0;
            mask_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mask_q <= 1'b0;
            done_q <= 1'b0;
            if (state_q == S_IDLE || state_q == S_DONE) begin
                cnt_q   <= 4'd0;
                stage_q <= 4'd0;
                pre_q   <= ONES;
                en_q    <= '0;
                state_q <= START ? (REFRESH_EN ? S_REFRESH : S_PRE) : S_IDLE;
                req_q   <= START && REFRESH_EN;
                busy_q  <= START;
            end else if (ABORT) begin
                state_q <= S_IDLE;
                cnt_q   <= 4'd0;
                stage_q <= 4'd0;
                pre_q   <= ONES;
                en_q    <= '0;
                req_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_REFRESH: begin
                        if (RND_VALID) begin
                            state_q <= S_PRE;
                            req_q   <= 1'b0;
                            mask_q  <= 1'b1;
                        end
                    end
                    S_PRE: begin
                        if (cnt_q == PRE_LAST) begin
                            state_q <= S_EVAL;
                            stage_q <= 4'd0;
                            en_q    <= NUM_STAGES'(1);
                            pre_q   <= ONES << 1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    S_EVAL: begin
                        // released stages stay released so their outputs hold until DONE
                        if (stage_q == LAST) begin
                            state_q <= S_DONE;
                            stage_q <= 4'd0;
                            pre_q   <= ONES;
                            en_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stage_q <= stage_q + 4'd1;
                            en_q    <= en_q << 1;
                            pre_q   <= pre_q << 1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
    assign RND_REQ = req_q;
    assign MASK_EN = mask_q;
    assign PRE     = pre_q;
    assign EN      = en_q;
    assign STAGE   = stage_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
endmodule
